dijkstra_ci_ctrl: RTL and testbench

//  Multi-cycle Nios II custom instruction that owns the Dijkstra node table (tentative distance + visited bit per node)
//  and sequences operations on it: init, write, read, edge relaxation, extract-min.

---
 rtl/dijkstra_ci_ctrl_if.sv | 31 +++
 rtl/dijkstra_ci_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_dijkstra_ci_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dijkstra_ci_ctrl_if.sv
// ---------------------------------------------------------------------------
// dijkstra_ci_ctrl_if
// Nios II multi-cycle custom-instruction port between the CPU (master) and the
// Dijkstra node-table controller (slave).
//   clk_en  CI clock enable; low freezes the whole instruction
//   start   one-cycle request pulse; n/dataa/datab are valid with it
//   n       opcode
//   dataa   node index operand
//   datab   distance operand
//   done    one-cycle completion pulse
//   result  instruction result, held between completions
// ---------------------------------------------------------------------------
interface dijkstra_ci_ctrl_if;
    logic        clk_en;
    logic        start;
    logic [2:0]  n;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;

    modport master (
        output clk_en, start, n, dataa, datab,
        input  done, result
    );

    modport slave (
        input  clk_en, start, n, dataa, datab,
        output done, result
    );
endinterface

// File: rtl/dijkstra_ci_ctrl.sv
// ---------------------------------------------------------------------------
// dijkstra_ci_ctrl
// Multi-cycle custom instruction that owns the Dijkstra node table (tentative
// distance plus visited bit per node) and runs one table operation per
// instruction: INIT, WRITE, READ, RELAX, EXTRACT (min over unvisited, reached
// nodes). Software walks the graph and issues one instruction per step.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset (released synchronously upstream)
//   ci     custom-instruction port (slave side): clk_en, start, n, dataa,
//          datab in; done, result out
// Distances live in a single-port RAM with registered read data; visited bits
// live in a flop vector so they can be cleared by reset.
// ---------------------------------------------------------------------------
module dijkstra_ci_ctrl #(
    parameter int NODES  = 64,
    parameter int DIST_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    dijkstra_ci_ctrl_if.slave  ci
);

    localparam int IDX_W = $clog2(NODES);
    localparam logic [DIST_W-1:0] INF = '1;

    localparam logic [2:0] OP_INIT    = 3'd0;
    localparam logic [2:0] OP_WRITE   = 3'd1;
    localparam logic [2:0] OP_READ    = 3'd2;
    localparam logic [2:0] OP_RELAX   = 3'd3;
    localparam logic [2:0] OP_EXTRACT = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        CLEAR,
        SCAN,
        FIN
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        op_q,       op_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [DIST_W-1:0] opnd_q,     opnd_d;
    logic [IDX_W:0]    cnt_q,      cnt_d;
    logic              found_q,    found_d;
    logic [IDX_W-1:0]  best_q,     best_d;
    logic [DIST_W-1:0] bestDist_q, bestDist_d;
    logic [NODES-1:0]  visited_q,  visited_d;
    logic [31:0]       result_q,   result_d;

    // RAM port signals; rd_q is the registered RAM output
    logic [IDX_W-1:0]  memAddr;
    logic              memWe;
    logic [DIST_W-1:0] memWdata;
    logic [DIST_W-1:0] rd_q;

    // Scan compare signals for the entry whose data is on rd_q this cycle
    logic [IDX_W-1:0]  scanIdx;
    logic              scanCand;
    logic              scanTake;
    logic              foundNext;
    logic [IDX_W-1:0]  bestNext;
    logic [DIST_W-1:0] bestDistNext;

    logic lastClear;
    logic lastScan;

    // Only the low index/distance bits matter; the rest wrap by design.
    logic unused_opnd_bits;
    assign unused_opnd_bits = ^{ci.dataa, ci.datab};

    assign lastClear = (cnt_q == (IDX_W+1)'(NODES - 1));
    assign lastScan  = (cnt_q == (IDX_W+1)'(NODES));

    // ------------------------------------------------------------------
    // Distance table: single-port RAM, one access per cycle. Reads are
    // registered, so data addressed in cycle k is compared in cycle k+1.
    // Gated by clk_en so a stall neither skips nor repeats an entry.
    // ------------------------------------------------------------------
    logic [DIST_W-1:0] distMem [NODES];

    always_ff @(posedge clk) begin
        if (ci.clk_en) begin
            if (memWe) begin
                distMem[memAddr] <= memWdata;
            end
            rd_q <= distMem[memAddr];
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else if (ci.clk_en) begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. start only matters in IDLE; INIT and EXTRACT take
    // the long sweeps, everything else (including reserved codes) takes a
    // single EXEC cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ci.start) begin
                    if (ci.n == OP_INIT) begin
                        state_d = CLEAR;
                    end else if (ci.n == OP_EXTRACT) begin
                        state_d = SCAN;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC:  state_d = FIN;
            CLEAR: if (lastClear) state_d = FIN;
            SCAN:  if (lastScan)  state_d = FIN;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Scan comparator. cnt_q=k has entry k-1 on rd_q (k=1..NODES). A strict
    // less-than keeps the earlier index on ties since entries arrive in
    // ascending order.
    // ------------------------------------------------------------------
    always_comb begin
        scanIdx      = cnt_q[IDX_W-1:0] - 1'b1;
        scanCand     = (cnt_q != '0) && !visited_q[scanIdx] && (rd_q != INF);
        scanTake     = scanCand && (!found_q || (rd_q < bestDist_q));
        foundNext    = found_q | scanTake;
        bestNext     = scanTake ? scanIdx : best_q;
        bestDistNext = scanTake ? rd_q    : bestDist_q;
    end

    // ------------------------------------------------------------------
    // Output / datapath logic per state. The IDLE cycle addresses the RAM
    // with the incoming index so that EXEC already sees dist[idx] on rd_q;
    // RELAX/WRITE then write back in EXEC, keeping one access per cycle.
    // result is only updated in the cycle that moves into FIN.
    // ------------------------------------------------------------------
    always_comb begin
        op_d       = op_q;
        idx_d      = idx_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        found_d    = found_q;
        best_d     = best_q;
        bestDist_d = bestDist_q;
        visited_d  = visited_q;
        result_d   = result_q;
        memAddr    = idx_q;
        memWe      = 1'b0;
        memWdata   = opnd_q;

        unique case (state_q)
            IDLE: begin
                memAddr = ci.dataa[IDX_W-1:0];
                cnt_d   = '0;
                found_d = 1'b0;
                if (ci.start) begin
                    op_d   = ci.n;
                    idx_d  = ci.dataa[IDX_W-1:0];
                    opnd_d = ci.datab[DIST_W-1:0];
                end
            end
            EXEC: begin
                memAddr  = idx_q;
                result_d = '0;
                unique case (op_q)
                    OP_WRITE: begin
                        memWe    = 1'b1;
                        memWdata = opnd_q;
                    end
                    OP_READ: begin
                        result_d = 32'(rd_q);
                    end
                    OP_RELAX: begin
                        if (!visited_q[idx_q] && (opnd_q < rd_q)) begin
                            memWe    = 1'b1;
                            memWdata = opnd_q;
                            result_d = 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
            CLEAR: begin
                memAddr                      = cnt_q[IDX_W-1:0];
                memWe                        = 1'b1;
                memWdata                     = INF;
                visited_d[cnt_q[IDX_W-1:0]]  = 1'b0;
                cnt_d                        = cnt_q + 1'b1;
                if (lastClear) begin
                    result_d = '0;
                end
            end
            SCAN: begin
                // At cnt_q==NODES the address wraps to 0; that read is unused.
                memAddr    = cnt_q[IDX_W-1:0];
                cnt_d      = cnt_q + 1'b1;
                found_d    = foundNext;
                best_d     = bestNext;
                bestDist_d = bestDistNext;
                if (lastScan) begin
                    if (foundNext) begin
                        result_d            = 32'(bestNext);
                        visited_d[bestNext] = 1'b1;
                    end else begin
                        result_d = 32'hFFFF_FFFF;
                    end
                end
            end
            FIN: ;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. Everything holds while clk_en is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= '0;
            idx_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            found_q    <= 1'b0;
            best_q     <= '0;
            bestDist_q <= '0;
            visited_q  <= '0;
            result_q   <= '0;
        end else if (ci.clk_en) begin
            op_q       <= op_d;
            idx_q      <= idx_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            found_q    <= found_d;
            best_q     <= best_d;
            bestDist_q <= bestDist_d;
            visited_q  <= visited_d;
            result_q   <= result_d;
        end
    end

    assign ci.done   = (state_q == FIN);
    assign ci.result = result_q;

endmodule

// File: tb/tb_dijkstra_ci_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dijkstra_ci_ctrl
// Directed and randomized instruction sequences against a behavioural model of
// the node table (plain arrays). Each instruction is checked for completion
// latency and result.
// ---------------------------------------------------------------------------
module tb_dijkstra_ci_ctrl;

    localparam int NODES = 64;
    localparam logic [31:0] INF = 32'hFFFF_FFFF;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    dijkstra_ci_ctrl_if ci ();

    dijkstra_ci_ctrl #(
        .NODES  (NODES),
        .DIST_W (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ci    (ci)
    );

    always #5 clk = ~clk;

    int cmpCount = 0;
    int errCount = 0;

    logic [31:0] mDist [NODES];
    bit          mVis  [NODES];

    // Compare one observed value against the expected one
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural table model: apply one instruction, return its result
    function automatic logic [31:0] modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int idx;
        logic [31:0] minVal;
        bit any;
        idx = int'(a % NODES);
        case (op)
            3'd0: begin
                foreach (mDist[i]) begin
                    mDist[i] = INF;
                    mVis[i]  = 1'b0;
                end
                return 32'd0;
            end
            3'd1: begin
                mDist[idx] = b;
                return 32'd0;
            end
            3'd2: return mDist[idx];
            3'd3: begin
                if (!mVis[idx] && b < mDist[idx]) begin
                    mDist[idx] = b;
                    return 32'd1;
                end
                return 32'd0;
            end
            3'd4: begin
                // First the smallest reached distance, then its first holder
                any    = 1'b0;
                minVal = INF;
                foreach (mDist[i]) begin
                    if (!mVis[i] && mDist[i] != INF && mDist[i] < minVal) begin
                        minVal = mDist[i];
                        any    = 1'b1;
                    end
                end
                if (!any) return INF;
                foreach (mDist[i]) begin
                    if (!mVis[i] && mDist[i] == minVal) begin
                        mVis[i] = 1'b1;
                        return 32'(i);
                    end
                end
                return INF;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int baseLatency(input logic [2:0] op);
        if (op == 3'd0) return NODES + 1;
        if (op == 3'd4) return NODES + 2;
        return 2;
    endfunction

    // Issue one instruction; optionally stall clk_en or pulse a stray start
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int stallAt = 0, input int stallLen = 0,
                                 input int junkAt = 0, input bit chkRes = 1'b1);
        logic [31:0] expRes;
        int expLat;
        int k;
        bit seen;
        string tag;
        tag    = $sformatf("op%0d(%0d,%0h)", op, a, b);
        expRes = modelOp(op, a, b);
        expLat = baseLatency(op) + stallLen;
        @(negedge clk);
        ci.start = 1'b1;
        ci.n     = op;
        ci.dataa = a;
        ci.datab = b;
        @(negedge clk);
        ci.start = 1'b0;
        ci.n     = 3'($urandom);
        ci.dataa = $urandom;
        ci.datab = $urandom;
        seen = 1'b0;
        for (k = 1; k <= 400; k++) begin
            if (ci.done) begin
                seen = 1'b1;
                break;
            end
            if (stallLen > 0 && k == stallAt) ci.clk_en = 1'b0;
            if (stallLen > 0 && k == stallAt + stallLen) ci.clk_en = 1'b1;
            if (junkAt > 0 && k == junkAt) begin
                ci.start = 1'b1;
                ci.n     = 3'd1;
                ci.dataa = 32'd6;
                ci.datab = 32'd99;
            end
            if (junkAt > 0 && k == junkAt + 1) ci.start = 1'b0;
            @(negedge clk);
        end
        ci.clk_en = 1'b1;
        ci.start  = 1'b0;
        checkOutput({tag, " latency"}, 32'(k), 32'(expLat));
        if (seen && chkRes) checkOutput({tag, " result"}, ci.result, expRes);
    endtask

    initial begin
        int doneCount;
        int r;
        logic [2:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        int sAt;
        int sLen;

        ci.clk_en = 1'b1;
        ci.start  = 1'b0;
        ci.n      = '0;
        ci.dataa  = '0;
        ci.datab  = '0;
        foreach (mDist[i]) begin
            mDist[i] = INF;
            mVis[i]  = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset done", 32'(ci.done), 32'd0);
        checkOutput("reset result", ci.result, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 1: INIT then every entry reads INF
        $display("[TB] INIT and full read-back");
        applyStimulus(3'd0, 0, 0);
        for (int i = 0; i < NODES; i++) applyStimulus(3'd2, 32'(i), 0);

        // 2: WRITE / RELAX rules
        $display("[TB] relax rules");
        applyStimulus(3'd0, 0, 0);
        applyStimulus(3'd1, 5, 10);
        applyStimulus(3'd3, 5, 12);
        applyStimulus(3'd3, 5, 7);
        applyStimulus(3'd3, 5, 7);
        applyStimulus(3'd2, 5, 0);

        // 3: EXTRACT ordering, ties, exhaustion, visited blocks relax
        $display("[TB] extract ordering");
        applyStimulus(3'd0, 0, 0);
        applyStimulus(3'd1, 3, 4);
        applyStimulus(3'd1, 9, 4);
        applyStimulus(3'd1, 1, 6);
        applyStimulus(3'd4, 0, 0);
        applyStimulus(3'd4, 0, 0);
        applyStimulus(3'd4, 0, 0);
        applyStimulus(3'd4, 0, 0);
        applyStimulus(3'd3, 3, 0);

        // 4: EXTRACT stalled mid-scan
        $display("[TB] stalled extract");
        applyStimulus(3'd0, 0, 0);
        applyStimulus(3'd1, 20, 50);
        applyStimulus(3'd1, 40, 30);
        applyStimulus(3'd1, 63, 30);
        applyStimulus(3'd4, 0, 0, 10, 5);
        applyStimulus(3'd4, 0, 0, 64, 3);
        applyStimulus(3'd4, 0, 0);

        // 5: reset during SCAN aborts the op
        $display("[TB] reset during scan");
        @(negedge clk);
        ci.start = 1'b1;
        ci.n     = 3'd4;
        ci.dataa = 0;
        @(negedge clk);
        ci.start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort done", 32'(ci.done), 32'd0);
        checkOutput("abort result", ci.result, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        foreach (mVis[i]) mVis[i] = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (ci.done) doneCount++;
        end
        checkOutput("abort no done", 32'(doneCount), 32'd0);
        checkOutput("abort result held", ci.result, 32'd0);
        applyStimulus(3'd2, 5, 0, 0, 0, 0, 1'b0);
        applyStimulus(3'd0, 0, 0);

        // 6: stray start while busy, index wrap
        $display("[TB] stray start and index wrap");
        applyStimulus(3'd4, 0, 0, 0, 0, 10);
        applyStimulus(3'd2, 6, 0);
        applyStimulus(3'd1, 70, 3);
        applyStimulus(3'd2, 6, 0);

        // Randomized instruction mix
        $display("[TB] random mix");
        for (int j = 0; j < 150; j++) begin
            r = $urandom_range(0, 99);
            rOp = (r < 3) ? 3'd0 : 3'($urandom_range(1, 7));
            rA  = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0)      rB = INF;
            else if (r == 1) rB = $urandom;
            else             rB = 32'($urandom_range(0, 40));
            sAt  = 0;
            sLen = 0;
            if ($urandom_range(0, 3) == 0) begin
                sLen = $urandom_range(1, 4);
                sAt  = $urandom_range(1, baseLatency(rOp) - 1);
            end
            applyStimulus(rOp, rA, rB, sAt, sLen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
